// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared widths, reset constants and fetch state encoding for the IF stage
package if_stage_pkg;

    localparam int BUS_64 = 64;
    localparam int BUS_32 = 32;

    localparam logic [BUS_64-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [BUS_32-1:0] INST_NOP_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - fetch PC / previous PC register with redirect-first next-PC selection
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   redirect          load redirect_pc (low two bits cleared); wins over advance
//   redirect_pc       redirect target
//   advance           step pc by 4 and copy the old pc into pc_old
//   pc, pc_old        current fetch PC, PC of the last handed-off instruction
//   pc_pred           pc + 4 (combinational)
module if_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [BUS_64-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [BUS_64-1:0] redirect_pc,
    input  logic              advance,
    output logic [BUS_64-1:0] pc,
    output logic [BUS_64-1:0] pc_old,
    output logic [BUS_64-1:0] pc_pred
);

    assign pc_pred = pc + 64'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            pc_old <= '0;
        end else if (redirect) begin
            // pc_old deliberately untouched: a redirect is not a hand-off
            pc <= redirect_pc & ~64'd3;
        end else if (advance) begin
            pc_old <= pc;
            pc     <= pc_pred;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: one outstanding 64-bit bus read, one held instruction
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   o_if_fetched_req / i_if_fetched_ack   instruction handshake toward decode
//   o_if_pc, o_if_inst, o_if_pc_old, o_if_pc_pred   presented instruction info
//   i_if_redirect, i_if_redirect_pc       redirect pulse and target
//   o_if_bus_req, i_if_bus_gnt, o_if_bus_addr     read request channel
//   i_if_bus_rvalid, i_if_bus_rdata       read response channel
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [BUS_64-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [BUS_32-1:0] INST_NOP = INST_NOP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_if_fetched_req,
    input  logic              i_if_fetched_ack,
    output logic [BUS_64-1:0] o_if_pc,
    output logic [BUS_32-1:0] o_if_inst,
    output logic [BUS_64-1:0] o_if_pc_old,
    output logic [BUS_64-1:0] o_if_pc_pred,
    input  logic              i_if_redirect,
    input  logic [BUS_64-1:0] i_if_redirect_pc,
    output logic              o_if_bus_req,
    input  logic              i_if_bus_gnt,
    output logic [BUS_64-1:0] o_if_bus_addr,
    input  logic              i_if_bus_rvalid,
    input  logic [BUS_64-1:0] i_if_bus_rdata
);

    fetch_state_t      state, state_n;
    logic              discard, discard_n;
    logic [BUS_32-1:0] inst_q;
    logic              inst_load;
    logic              advance;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .redirect    (i_if_redirect),
        .redirect_pc (i_if_redirect_pc),
        .advance     (advance),
        .pc          (o_if_pc),
        .pc_old      (o_if_pc_old),
        .pc_pred     (o_if_pc_pred)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            discard <= 1'b0;
            inst_q  <= INST_NOP;
        end else begin
            state   <= state_n;
            discard <= discard_n;
            if (inst_load) begin
                inst_q <= o_if_pc[2] ? i_if_bus_rdata[63:32] : i_if_bus_rdata[31:0];
            end
        end
    end

    always_comb begin
        state_n   = state;
        discard_n = discard;
        inst_load = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE: state_n = ST_REQ;
            ST_REQ: begin
                if (i_if_bus_gnt) begin
                    state_n = ST_WAIT;
                    // the granted read targets the old pc; its response must be swallowed
                    if (i_if_redirect) discard_n = 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_if_bus_rvalid) begin
                    // a response arriving together with a redirect is stale as well
                    discard_n = 1'b0;
                    if (discard || i_if_redirect) begin
                        state_n = ST_REQ;
                    end else begin
                        inst_load = 1'b1;
                        state_n   = ST_OUT;
                    end
                end else if (i_if_redirect) begin
                    discard_n = 1'b1;
                end
            end
            ST_OUT: begin
                if (i_if_redirect) begin
                    state_n = ST_REQ;
                end else if (i_if_fetched_ack) begin
                    advance = 1'b1;
                    state_n = ST_REQ;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign o_if_fetched_req = (state == ST_OUT);
    assign o_if_bus_req     = (state == ST_REQ);
    assign o_if_bus_addr    = o_if_pc & ~64'd7;
    assign o_if_inst        = (state == ST_OUT) ? inst_q : INST_NOP;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage: directed vector table plus randomized bus/decode traffic
module tb_if_stage;

    localparam logic [63:0] PC0 = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [63:0] D0  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D1  = 64'h5555_6666_7777_8888;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_if_fetched_req;
    logic        i_if_fetched_ack;
    logic [63:0] o_if_pc;
    logic [31:0] o_if_inst;
    logic [63:0] o_if_pc_old;
    logic [63:0] o_if_pc_pred;
    logic        i_if_redirect;
    logic [63:0] i_if_redirect_pc;
    logic        o_if_bus_req;
    logic        i_if_bus_gnt;
    logic [63:0] o_if_bus_addr;
    logic        i_if_bus_rvalid;
    logic [63:0] i_if_bus_rdata;

    always #5 clk = ~clk;

    if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .o_if_fetched_req (o_if_fetched_req),
        .i_if_fetched_ack (i_if_fetched_ack),
        .o_if_pc          (o_if_pc),
        .o_if_inst        (o_if_inst),
        .o_if_pc_old      (o_if_pc_old),
        .o_if_pc_pred     (o_if_pc_pred),
        .i_if_redirect    (i_if_redirect),
        .i_if_redirect_pc (i_if_redirect_pc),
        .o_if_bus_req     (o_if_bus_req),
        .i_if_bus_gnt     (i_if_bus_gnt),
        .o_if_bus_addr    (o_if_bus_addr),
        .i_if_bus_rvalid  (i_if_bus_rvalid),
        .i_if_bus_rdata   (i_if_bus_rdata)
    );

    typedef struct {
        logic        rst, gnt, rv, ack, rd;
        logic [63:0] rpc, rdata;
        logic        e_freq, e_breq;
        logic [63:0] e_pc, e_pc_old;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    task automatic add(input logic r, g, v, a, d, input logic [63:0] rpc, rdata,
                       input logic ef, eb, input logic [63:0] ep, epo, input logic [31:0] ei);
        vec_t t;
        t.rst = r; t.gnt = g; t.rv = v; t.ack = a; t.rd = d; t.rpc = rpc; t.rdata = rdata;
        t.e_freq = ef; t.e_breq = eb; t.e_pc = ep; t.e_pc_old = epo; t.e_inst = ei;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic r, g, v, a, d, input logic [63:0] rpc, rdata);
        rst = r; i_if_bus_gnt = g; i_if_bus_rvalid = v; i_if_fetched_ack = a;
        i_if_redirect = d; i_if_redirect_pc = rpc; i_if_bus_rdata = rdata;
    endtask

    // memory contents: each 32-bit word is a hash of its own byte address
    function automatic logic [31:0] fword(input logic [63:0] a);
        logic [31:0] m;
        m = a[31:0] * 32'h9E37_79B1;
        return m ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [63:0] mem64(input logic [63:0] a);
        return {fword(a + 64'd4), fword(a)};
    endfunction

    task automatic fail_msg(input string name, input logic [63:0] act, input logic [63:0] req);
        miss_cnt++;
        $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    logic [63:0] exp_pc, last_pc, ob_addr, hp_pc, r_rpc, r_rdata;
    logic [31:0] hp_inst;
    logic        outst, hold_prev, breq, r_rst, r_rd, r_ack, r_gnt, r_rv;
    int          dly, hs;

    initial begin
        drive(1, 0, 0, 0, 0, 64'd0, 64'd0);

        //   rst g rv ak rd rpc                     rdata  freq breq pc                      pc_old                  inst
        add(1, 0, 0, 0, 0, 64'd0,                   64'd0, 0, 0, PC0,                    64'd0,                  NOP);
        add(0, 0, 0, 0, 0, 64'd0,                   64'd0, 0, 1, PC0,                    64'd0,                  NOP);
        add(0, 1, 0, 1, 0, 64'd0,                   64'd0, 0, 0, PC0,                    64'd0,                  NOP);
        add(0, 0, 1, 1, 0, 64'd0,                   D0,    1, 0, PC0,                    64'd0,                  32'h3333_4444);
        add(0, 0, 0, 1, 0, 64'd0,                   64'd0, 0, 1, PC0 + 4,                PC0,                    NOP);
        add(0, 1, 0, 1, 0, 64'd0,                   64'd0, 0, 0, PC0 + 4,                PC0,                    NOP);
        add(0, 0, 1, 0, 0, 64'd0,                   D0,    1, 0, PC0 + 4,                PC0,                    32'h1111_2222);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0, 0, 64'd0,               64'd0, 1, 0, PC0 + 4,                PC0,                    32'h1111_2222);
        add(0, 0, 0, 1, 0, 64'd0,                   64'd0, 0, 1, PC0 + 8,                PC0 + 4,                NOP);
        add(0, 1, 0, 0, 0, 64'd0,                   64'd0, 0, 0, PC0 + 8,                PC0 + 4,                NOP);
        add(0, 0, 0, 0, 1, 64'h8000_1002,           64'd0, 0, 0, 64'h8000_1000,          PC0 + 4,                NOP);
        add(0, 0, 0, 0, 0, 64'd0,                   64'd0, 0, 0, 64'h8000_1000,          PC0 + 4,                NOP);
        add(0, 0, 1, 0, 0, 64'd0,                   D0,    0, 1, 64'h8000_1000,          PC0 + 4,                NOP);
        add(0, 1, 0, 0, 0, 64'd0,                   64'd0, 0, 0, 64'h8000_1000,          PC0 + 4,                NOP);
        add(0, 0, 1, 0, 0, 64'd0,                   D1,    1, 0, 64'h8000_1000,          PC0 + 4,                32'h7777_8888);
        add(0, 0, 0, 1, 1, 64'h8000_2008,           64'd0, 0, 1, 64'h8000_2008,          PC0 + 4,                NOP);
        add(0, 1, 0, 0, 1, 64'h8000_3004,           64'd0, 0, 0, 64'h8000_3004,          PC0 + 4,                NOP);
        add(0, 0, 1, 0, 0, 64'd0,                   D1,    0, 1, 64'h8000_3004,          PC0 + 4,                NOP);
        add(0, 1, 0, 0, 0, 64'd0,                   64'd0, 0, 0, 64'h8000_3004,          PC0 + 4,                NOP);
        add(0, 0, 1, 0, 0, 64'd0,                   D1,    1, 0, 64'h8000_3004,          PC0 + 4,                32'h5555_6666);
        add(0, 0, 0, 1, 0, 64'd0,                   64'd0, 0, 1, 64'h8000_3008,          64'h8000_3004,          NOP);
        add(0, 1, 0, 0, 0, 64'd0,                   64'd0, 0, 0, 64'h8000_3008,          64'h8000_3004,          NOP);
        add(1, 0, 0, 0, 0, 64'd0,                   64'd0, 0, 0, PC0,                    64'd0,                  NOP);
        add(0, 0, 1, 0, 0, 64'd0,                   D1,    0, 1, PC0,                    64'd0,                  NOP);
        add(0, 0, 0, 0, 0, 64'd0,                   64'd0, 0, 1, PC0,                    64'd0,                  NOP);
        add(0, 1, 0, 0, 0, 64'd0,                   64'd0, 0, 0, PC0,                    64'd0,                  NOP);
        add(0, 0, 1, 0, 0, 64'd0,                   D0,    1, 0, PC0,                    64'd0,                  32'h3333_4444);
        add(0, 0, 0, 1, 0, 64'd0,                   64'd0, 0, 1, PC0 + 4,                PC0,                    NOP);
        add(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, PC0,                    NOP);
        add(0, 1, 0, 0, 0, 64'd0,                   64'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, PC0,                    NOP);
        add(0, 0, 1, 0, 0, 64'd0,                   D1,    1, 0, 64'hFFFF_FFFF_FFFF_FFFC, PC0,                    32'h5555_6666);
        add(0, 0, 0, 1, 0, 64'd0,                   64'd0, 0, 1, 64'd0,                  64'hFFFF_FFFF_FFFF_FFFC, NOP);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].gnt, tbl[i].rv, tbl[i].ack, tbl[i].rd, tbl[i].rpc, tbl[i].rdata);
            @(posedge clk);
            #1;
            vec_cnt++;
            if (o_if_fetched_req !== tbl[i].e_freq || o_if_bus_req !== tbl[i].e_breq ||
                o_if_pc !== tbl[i].e_pc || o_if_pc_old !== tbl[i].e_pc_old ||
                o_if_inst !== tbl[i].e_inst || o_if_pc_pred !== tbl[i].e_pc + 64'd4 ||
                (tbl[i].e_breq && o_if_bus_addr !== (tbl[i].e_pc & ~64'd7))) begin
                miss_cnt++;
                $display("FAIL vec%0d: got req=%0b bus_req=%0b pc=%h pc_old=%h inst=%h pred=%h addr=%h, required req=%0b bus_req=%0b pc=%h pc_old=%h inst=%h",
                         i, o_if_fetched_req, o_if_bus_req, o_if_pc, o_if_pc_old, o_if_inst, o_if_pc_pred,
                         o_if_bus_addr, tbl[i].e_freq, tbl[i].e_breq, tbl[i].e_pc, tbl[i].e_pc_old, tbl[i].e_inst);
            end
        end

        // randomized traffic against a transaction-level model of the fetch PC sequence
        exp_pc = PC0; last_pc = '0; ob_addr = '0; outst = 0; dly = 0; hold_prev = 0; hs = 0;
        hp_pc = '0; hp_inst = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc != 0) begin
                vec_cnt++;
                if (o_if_pc !== exp_pc) fail_msg("pc_track", o_if_pc, exp_pc);
                if (o_if_bus_req) begin
                    vec_cnt++;
                    if (outst) fail_msg("second_outstanding", 64'd1, 64'd0);
                    else if (o_if_bus_addr !== (exp_pc & ~64'd7)) fail_msg("bus_addr", o_if_bus_addr, exp_pc & ~64'd7);
                end
                if (hold_prev) begin
                    vec_cnt++;
                    if (!o_if_fetched_req || o_if_pc !== hp_pc || o_if_inst !== hp_inst)
                        fail_msg("hold_stable", {o_if_pc[31:0], o_if_inst}, {hp_pc[31:0], hp_inst});
                end
            end

            r_rst = (cyc == 0) || ($urandom_range(0, 299) == 0);
            r_rd  = ($urandom_range(0, 11) == 0);
            r_rpc = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) r_rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            r_ack = ($urandom_range(0, 2) != 0);
            r_gnt = ($urandom_range(0, 1) == 1);
            if (outst && dly == 0) begin
                r_rv = 1'b1;
                r_rdata = mem64(ob_addr);
            end else begin
                r_rv = !outst && ($urandom_range(0, 7) == 0);
                r_rdata = {$urandom, $urandom};
            end
            drive(r_rst, r_gnt, r_rv, r_ack, r_rd, r_rpc, r_rdata);

            if (!r_rst && !r_rd && o_if_fetched_req && r_ack) begin
                vec_cnt++;
                if (o_if_pc !== exp_pc || o_if_inst !== fword(exp_pc) ||
                    o_if_pc_old !== last_pc || o_if_pc_pred !== exp_pc + 64'd4)
                    fail_msg("handoff", {o_if_pc[31:0], o_if_inst}, {exp_pc[31:0], fword(exp_pc)});
                last_pc = exp_pc;
                exp_pc  = exp_pc + 64'd4;
                hs++;
            end
            hold_prev = !r_rst && !r_rd && o_if_fetched_req && !r_ack;
            hp_pc     = o_if_pc;
            hp_inst   = o_if_inst;
            if (r_rst) begin
                exp_pc  = PC0;
                last_pc = '0;
            end else if (r_rd) begin
                exp_pc = r_rpc & ~64'd3;
            end

            breq = o_if_bus_req;
            if (r_rst) begin
                outst = 0;
            end else if (outst) begin
                if (r_rv) outst = 0;
                else dly--;
            end else if (breq && r_gnt) begin
                outst   = 1;
                ob_addr = o_if_bus_addr;
                dly     = $urandom_range(0, 3);
            end
            @(posedge clk);
        end

        vec_cnt++;
        if (hs < 100) fail_msg("progress", 64'(hs), 64'd100);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the architectural fetch PC and issues one 64-bit aligned read per instruction on a simple request/grant/response instruction bus.
- Extracts the 32-bit instruction and presents it to decode with a req/ack handshake, together with pc, pc_old and pc_pred.
- Accepts a redirect (branch/jump/trap target) from later stages, which flushes any in-flight fetch.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
- INST_NOP, 32'h0000_0013, instruction value driven on o_if_inst while no valid fetch is held.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- o_if_fetched_req  out  1  fetched instruction valid toward decode
- i_if_fetched_ack  in  1  decode accepts; handshake completes on req&ack
- o_if_pc  out  64  PC of presented instruction
- o_if_inst  out  32  presented instruction
- o_if_pc_old  out  64  PC of previously handed-off instruction
- o_if_pc_pred  out  64  predicted next PC (o_if_pc+4)
- i_if_redirect  in  1  one-cycle redirect pulse
- i_if_redirect_pc  in  64  redirect target; bits [1:0] ignored
- o_if_bus_req  out  1  read request
- i_if_bus_gnt  in  1  request accepted this cycle
- o_if_bus_addr  out  64  {pc[63:3],3'b000}
- i_if_bus_rvalid  in  1  read data valid, one cycle
- i_if_bus_rdata  in  64  read data

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC, pc_old=0
  - o_if_fetched_req=0, o_if_bus_req=0, o_if_inst=INST_NOP
  - discard flag=0
  - o_if_pc_pred = pc+4 (combinational from pc)
- At most one bus transaction outstanding. Exactly one instruction is held at a time.
- States:
  - IDLE -> REQ unconditionally, next cycle.
  - REQ: o_if_bus_req=1, o_if_bus_addr from pc. On i_if_bus_gnt -> WAIT.
  - WAIT: on i_if_bus_rvalid:
    - discard=1: clear discard, -> REQ; the data is dropped.
    - discard=0: latch inst = pc[2] ? rdata[63:32] : rdata[31:0], -> OUT.
  - OUT: o_if_fetched_req=1, held stable until ack. On i_if_fetched_ack: pc_old<=pc, pc<=pc+4, -> REQ. o_if_fetched_req deasserts the next cycle.
- Latency: grant at cycle t, rvalid at t+k gives o_if_fetched_req=1 at t+k+1. Minimum back-to-back throughput is one instruction per 3 cycles with a zero-wait bus.
- Redirect (i_if_redirect=1) has priority over every other event:
  - IDLE/REQ without gnt: pc<=target, stay/enter REQ. The request is re-driven with the new address.
  - REQ with gnt in the same cycle: -> WAIT, discard<=1, pc<=target.
  - WAIT without rvalid: discard<=1, pc<=target.
  - WAIT with rvalid in the same cycle: drop the data, discard stays 0, pc<=target, -> REQ.
  - OUT (with or without ack): o_if_fetched_req<=0, pc<=target, pc_old unchanged, -> REQ. The ack is ignored, so no handshake occurs.
  - Redirect while discard=1: only pc is updated; the pending discard still absorbs the one outstanding response.
- o_if_pc, o_if_inst and o_if_pc_old change only on state transitions. They are stable while o_if_fetched_req=1.
- PC arithmetic is 64-bit modulo. pc+4 wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.
- rst asserted mid-transaction returns to the reset state immediately. The bus must tolerate an abandoned request; a late rvalid arriving in IDLE/REQ is ignored.
- i_if_bus_rvalid outside WAIT is ignored.

Decomposition:
- Shared defines: `BUS_64 and `BUS_32 widths, RESET_PC value, NOP encoding, and the 2-bit fetch state encodings (IDLE/REQ/WAIT/OUT).
- One natural sub-module, if_pc_reg: holds pc/pc_old and applies next-PC selection (redirect, pc+4, hold), with redirect highest priority. The FSM and bus/handshake logic remain in if_stage.

Test Plan:
- Reset release, zero-wait bus (gnt same cycle, rvalid next), ack held 1:
  - first o_if_bus_addr=0x80000000.
  - o_if_fetched_req rises 3 cycles after reset deassert, with pc=0x80000000, inst=rdata[31:0].
  - second instruction has pc=0x80000004, inst=rdata[63:32], pc_old=0x80000000.
- Ack held 0 for 5 cycles in OUT -> req, pc and inst stay constant and no new bus_req is issued. Ack=1 -> pc advances by 4 on the next cycle.
- Redirect to 0x80001002 during WAIT, then rvalid two cycles later:
  - the response is discarded and o_if_fetched_req stays 0.
  - the next bus_addr is 0x80001000.
  - the presented pc is 0x80001000 and inst is the low word.
- Redirect and ack in the same cycle in OUT:
  - no pc+4 step and pc_old is unchanged.
  - the next fetch is at the redirect target.
- Redirect coincident with gnt in REQ:
  - the following rvalid is dropped.
  - a fresh request is issued to the target and exactly one instruction is delivered.
- Reset asserted during WAIT, then a stray rvalid in the next cycle:
  - outputs return to reset values and the stray rvalid is ignored.
  - fetch restarts at 0x80000000.
